// File: rtl/pipelined_alu_pkg.sv
// Shared constants for the pipelined execute-stage ALU: opcodes, FSM states, NZCV bit indices.
package pipelined_alu_pkg;

  typedef enum logic [3:0] {
    OpAnd   = 4'b0000,
    OpOr    = 4'b0001,
    OpAdd   = 4'b0010,
    OpXor   = 4'b0011,
    OpLsl   = 4'b0100,
    OpLsr   = 4'b0101,
    OpSub   = 4'b0110,
    OpPassB = 4'b0111,
    OpAsr   = 4'b1000,
    OpMul   = 4'b1001,
    OpUdiv  = 4'b1010,
    OpSdiv  = 4'b1011,
    OpNor   = 4'b1100
  } alu_op_e;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StIter = 1'b1
  } alu_state_e;

  // Bit positions inside the packed NZCV flag register.
  localparam int unsigned FlagV = 0;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagN = 3;

  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OpMul) || (op == OpUdiv) || (op == OpSdiv);
  endfunction

endpackage

// File: rtl/pipelined_alu_if.sv
// Request/response bundle between the operand-read stage and the ALU.
interface pipelined_alu_if #(
  parameter int unsigned WIDTH = 64
);
  logic             start;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             valid;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             negative;
  logic             carry;
  logic             overflow;
  logic             div_by_zero;

  modport master (
    output start, alu_control, a, b,
    input  ready, valid, result, zero, negative, carry, overflow, div_by_zero
  );

  modport slave (
    input  start, alu_control, a, b,
    output ready, valid, result, zero, negative, carry, overflow, div_by_zero
  );
endinterface

// File: rtl/pipelined_alu_iter_unit.sv
// Shared shift-add multiplier and restoring divider; one step per cycle for WIDTH cycles.
module pipelined_alu_iter_unit
  import pipelined_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);
  localparam int unsigned CW = $clog2(WIDTH);

  // acc: product accumulator / partial remainder; x: multiplicand / divisor;
  // y: multiplier / dividend shifting into quotient.
  logic             busy_q, is_mul_q, neg_q, dz_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q, x_q, y_q;
  logic [WIDTH-1:0] acc_d, x_d, y_d;
  logic [WIDTH:0]   rem_sh, diff;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  // Operand conditioning at load: SDIV works on magnitudes.
  always_comb begin
    a_neg = (op == OpSdiv) && a[WIDTH-1];
    b_neg = (op == OpSdiv) && b[WIDTH-1];
    mag_a = a_neg ? (~a + 1'b1) : a;
    mag_b = b_neg ? (~b + 1'b1) : b;
  end

  // One multiply or divide step.
  always_comb begin
    rem_sh = {acc_q, y_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, x_q};
    if (is_mul_q) begin
      acc_d = y_q[0] ? (acc_q + x_q) : acc_q;
      x_d   = x_q << 1;
      y_d   = y_q >> 1;
    end else begin
      x_d = x_q;
      if (!diff[WIDTH]) begin
        acc_d = diff[WIDTH-1:0];
        y_d   = {y_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = rem_sh[WIDTH-1:0];
        y_d   = {y_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Result is presented during the final step so the top can register it that edge.
  always_comb begin
    done        = busy_q && (cnt_q == '0);
    div_by_zero = !is_mul_q && dz_q;
    if (is_mul_q)  result = acc_d;
    else if (dz_q) result = '0;
    else if (neg_q) result = ~y_d + 1'b1;
    else           result = y_d;
  end

  // Iteration state; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q   <= 1'b0;
      is_mul_q <= 1'b0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
    end else if (load) begin
      busy_q   <= 1'b1;
      is_mul_q <= (op == OpMul);
      neg_q    <= a_neg ^ b_neg;
      dz_q     <= (b == '0);
      cnt_q    <= CW'(WIDTH - 1);
      acc_q    <= '0;
      x_q      <= (op == OpMul) ? a : mag_b;
      y_q      <= (op == OpMul) ? b : mag_a;
    end else if (busy_q) begin
      acc_q <= acc_d;
      x_q   <= x_d;
      y_q   <= y_d;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == '0) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/pipelined_alu.sv
// Registered execute-stage ALU: single-cycle ops in one clock, MUL/UDIV/SDIV iterative.
module pipelined_alu
  import pipelined_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic            clk,
  input  logic            reset,
  pipelined_alu_if.slave  bus
);
  alu_state_e       state_q;
  logic             valid_q, dz_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;

  logic [WIDTH:0]   sum_c;
  logic [WIDTH-1:0] res_c;
  logic             c_c, v_c;
  logic [SHW-1:0]   sh;
  logic             load, iter_done, iter_dz;
  logic [WIDTH-1:0] iter_result;

  assign load = bus.start && (state_q == StIdle) && is_iter_op(bus.alu_control);

  pipelined_alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .op          (bus.alu_control),
    .a           (bus.a),
    .b           (bus.b),
    .done        (iter_done),
    .result      (iter_result),
    .div_by_zero (iter_dz)
  );

  // Single-cycle datapath and its carry/overflow.
  always_comb begin
    sh    = bus.b[SHW-1:0];
    sum_c = '0;
    res_c = '0;
    c_c   = 1'b0;
    v_c   = 1'b0;
    case (bus.alu_control)
      OpAnd:   res_c = bus.a & bus.b;
      OpOr:    res_c = bus.a | bus.b;
      OpXor:   res_c = bus.a ^ bus.b;
      OpNor:   res_c = ~(bus.a | bus.b);
      OpPassB: res_c = bus.b;
      OpLsl:   res_c = bus.a << sh;
      OpLsr:   res_c = bus.a >> sh;
      OpAsr:   res_c = WIDTH'($signed(bus.a) >>> sh);
      OpAdd: begin
        sum_c = {1'b0, bus.a} + {1'b0, bus.b};
        res_c = sum_c[WIDTH-1:0];
        c_c   = sum_c[WIDTH];
        v_c   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (res_c[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OpSub: begin
        sum_c = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH + 1)'(1);
        res_c = sum_c[WIDTH-1:0];
        c_c   = sum_c[WIDTH];
        v_c   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (res_c[WIDTH-1] != bus.a[WIDTH-1]);
      end
      default: res_c = '0;
    endcase
  end

  // Control FSM with registered result, flags and valid pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      valid_q  <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      dz_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            if (is_iter_op(bus.alu_control)) begin
              state_q <= StIter;
            end else begin
              valid_q        <= 1'b1;
              result_q       <= res_c;
              flags_q[FlagN] <= res_c[WIDTH-1];
              flags_q[FlagZ] <= (res_c == '0);
              flags_q[FlagC] <= c_c;
              flags_q[FlagV] <= v_c;
              dz_q           <= 1'b0;
            end
          end
        end
        StIter: begin
          if (iter_done) begin
            state_q        <= StIdle;
            valid_q        <= 1'b1;
            result_q       <= iter_result;
            flags_q[FlagN] <= iter_result[WIDTH-1];
            flags_q[FlagZ] <= (iter_result == '0);
            flags_q[FlagC] <= 1'b0;
            flags_q[FlagV] <= 1'b0;
            dz_q           <= iter_dz;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ready       = (state_q == StIdle);
  assign bus.valid       = valid_q;
  assign bus.result      = result_q;
  assign bus.negative    = flags_q[FlagN];
  assign bus.zero        = flags_q[FlagZ];
  assign bus.carry       = flags_q[FlagC];
  assign bus.overflow    = flags_q[FlagV];
  assign bus.div_by_zero = dz_q;

endmodule

// File: tb/tb_pipelined_alu.sv
// Directed and randomised checks of pipelined_alu against an arithmetic reference model.
module tb_pipelined_alu;
  localparam int unsigned W = 64;
  localparam logic signed [127:0] SMAX = 128'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [127:0] SMIN = -SMAX - 1;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  typedef struct {
    logic [63:0] r;
    logic n, z, c, v, dz;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   lat, rdy_low, nvalid;
  exp_t e;

  pipelined_alu_if #(.WIDTH(W)) bus ();

  pipelined_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    exp_t m;
    logic [64:0] u;
    logic signed [127:0] s, sa, sb;
    logic [5:0] amt;
    amt = b[5:0];
    sa  = $signed({{64{a[63]}}, a});
    sb  = $signed({{64{b[63]}}, b});
    m.r = '0; m.c = 1'b0; m.v = 1'b0; m.dz = 1'b0;
    case (op)
      4'd0:  m.r = a & b;
      4'd1:  m.r = a | b;
      4'd2: begin
        u = {1'b0, a} + {1'b0, b};
        m.r = u[63:0]; m.c = u[64];
        s = sa + sb; m.v = (s > SMAX) || (s < SMIN);
      end
      4'd3:  m.r = a ^ b;
      4'd4:  m.r = a << amt;
      4'd5:  m.r = a >> amt;
      4'd6: begin
        m.r = a - b; m.c = (a >= b);
        s = sa - sb; m.v = (s > SMAX) || (s < SMIN);
      end
      4'd7:  m.r = b;
      4'd8:  m.r = $signed(a) >>> amt;
      4'd9:  m.r = a * b;
      4'd10: if (b == 0) m.dz = 1'b1; else m.r = a / b;
      4'd11: begin
        if (b == 0) m.dz = 1'b1;
        else if (a == MINV && b == '1) m.r = MINV;
        else m.r = $signed(a) / $signed(b);
      end
      4'd12: m.r = ~(a | b);
      default: m.r = '0;
    endcase
    m.n = m.r[63];
    m.z = (m.r == 0);
    return m;
  endfunction

  // Issue one op, wait (bounded) for valid, and compare everything against the model.
  // When stray is set, an extra start is pulsed while the unit is busy.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b, input bit stray);
    bit iter;
    e = model(op, a, b);
    iter = (op == 4'd9) || (op == 4'd10) || (op == 4'd11);
    @(negedge clk);
    bus.start = 1'b1; bus.alu_control = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1; rdy_low = 0;
    while (!bus.valid && lat < 200) begin
      if (!bus.ready) rdy_low++;
      if (stray && lat == 5) begin
        bus.start = 1'b1; bus.alu_control = 4'd2; bus.a = 64'd1; bus.b = 64'd1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    check({tag, "_latency"}, 64'(lat), iter ? 64'd65 : 64'd1);
    if (iter) check({tag, "_ready_low"}, 64'(rdy_low), 64'd64);
    check({tag, "_ready_at_valid"}, 64'(bus.ready), 64'd1);
    check({tag, "_result"}, bus.result, e.r);
    check({tag, "_nzcv"}, {60'd0, bus.negative, bus.zero, bus.carry, bus.overflow},
          {60'd0, e.n, e.z, e.c, e.v});
    check({tag, "_dz"}, 64'(bus.div_by_zero), 64'(e.dz));
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.alu_control = '0; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 64'(bus.ready), 64'd1);
    check("reset_valid", 64'(bus.valid), 64'd0);
    check("reset_result", bus.result, 64'd0);
    check("reset_flags", {59'd0, bus.negative, bus.zero, bus.carry, bus.overflow,
          bus.div_by_zero}, 64'd0);
    reset = 1'b0;

    run_op("add_ovf", 4'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    check("add_ovf_const", bus.result, MINV);
    check("add_ovf_nzcv", {60'd0, bus.negative, bus.zero, bus.carry, bus.overflow}, 64'b1001);
    run_op("sub_eq", 4'd6, 64'd5, 64'd5, 1'b0);
    check("sub_eq_nzcv", {60'd0, bus.negative, bus.zero, bus.carry, bus.overflow}, 64'b0110);
    run_op("sub_borrow", 4'd6, 64'd0, 64'd1, 1'b0);
    check("sub_borrow_const", bus.result, '1);
    run_op("mul_neg", 4'd9, -64'sd3, 64'd7, 1'b1);
    check("mul_neg_const", bus.result, -64'sd21);
    @(posedge clk); #1;
    check("mul_single_valid", 64'(bus.valid), 64'd0);
    run_op("sdiv_neg", 4'd11, -64'sd7, 64'd2, 1'b0);
    check("sdiv_neg_const", bus.result, -64'sd3);
    run_op("sdiv_min", 4'd11, MINV, '1, 1'b0);
    check("sdiv_min_const", bus.result, MINV);
    run_op("udiv_zero", 4'd10, 64'd9, 64'd0, 1'b0);
    check("udiv_zero_dz", 64'(bus.div_by_zero), 64'd1);
    run_op("add_after_dz", 4'd2, 64'd1, 64'd1, 1'b0);
    check("add_after_dz_const", bus.result, 64'd2);
    run_op("asr", 4'd8, MINV, 64'h43, 1'b0);
    check("asr_const", bus.result, 64'hF000_0000_0000_0000);
    run_op("lsr", 4'd5, MINV, 64'h43, 1'b0);
    check("lsr_const", bus.result, 64'h1000_0000_0000_0000);
    run_op("unused", 4'd15, 64'h1234, 64'h5678, 1'b0);

    // Back-to-back single-cycle ops.
    @(negedge clk);
    bus.start = 1'b1; bus.alu_control = 4'd0;
    bus.a = 64'hF0F0_1234_5678_9ABC; bus.b = 64'h0FF0_FFFF_0000_FFFF;
    @(posedge clk); #1;
    bus.alu_control = 4'd1;
    check("b2b_and_valid", 64'(bus.valid), 64'd1);
    check("b2b_and", bus.result, 64'h00F0_1234_0000_9ABC);
    @(posedge clk); #1;
    bus.alu_control = 4'd3;
    check("b2b_or_valid", 64'(bus.valid), 64'd1);
    check("b2b_or", bus.result, 64'hFFF0_FFFF_5678_FFFF);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("b2b_xor_valid", 64'(bus.valid), 64'd1);
    check("b2b_xor", bus.result, 64'hFF00_EDCB_5678_6543);
    @(posedge clk); #1;
    check("b2b_end_valid", 64'(bus.valid), 64'd0);

    // Reset in the middle of an iterative op.
    @(negedge clk);
    bus.start = 1'b1; bus.alu_control = 4'd9; bus.a = 64'd11; bus.b = 64'd13;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midreset_ready", 64'(bus.ready), 64'd1);
    check("midreset_valid", 64'(bus.valid), 64'd0);
    check("midreset_result", bus.result, 64'd0);
    check("midreset_flags", {59'd0, bus.negative, bus.zero, bus.carry, bus.overflow,
          bus.div_by_zero}, 64'd0);
    nvalid = 0;
    repeat (70) begin
      @(posedge clk); #1;
      if (bus.valid) nvalid++;
    end
    check("midreset_no_valid", 64'(nvalid), 64'd0);

    // Randomised ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [3:0]  op;
      logic [63:0] ra, rb;
      op = 4'($urandom_range(0, 15));
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: rb = 64'($urandom_range(0, 9));
        1: rb = -64'($urandom_range(1, 9));
        default: ;
      endcase
      run_op($sformatf("rand%0d_op%0d", i, op), op, ra, rb, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
